eq_reg_bank: RTL and testbench
==============================

# eq_reg_bank

Register bank sitting directly downstream of the AXI4-Lite-to-simple-bus adapter: it decodes the adapter's `wr`/`rd` strobes, holds the equalizer's per-band gain coefficients, and returns read data combinationally on `rdData`. Gains are double-buffered. Software writes shadow copies, then requests a commit, and the bank moves shadow to active on the next audio sample strobe, so the filter datapath never sees a half-updated coefficient set. The bank also carries control bits, a sample counter and clip status back from the datapath.

## Interface
- `C_S_AXI_ADDR_WIDTH`, 6, simple-bus byte-address width
- `C_S_AXI_DATA_WIDTH`, 32, simple-bus data width
- `NUM_BANDS`, 8, number of gain registers (max 8)
- `GAIN_WIDTH`, 16, gain width; signed Q2.14
- `GAIN_RESET`, 16'h4000, reset gain (unity)

Ports:
- `S_AXI_ACLK`  in  1  sole clock
- `S_AXI_ARESET`  in  1  reset; asynchronous, active-high (fixed decision)
- `wrAddr`  in  ADDR_WIDTH  write byte address
- `wrData`  in  DATA_WIDTH  write data
- `wr`  in  1  one-cycle write strobe
- `rdAddr`  in  ADDR_WIDTH  read byte address
- `rd`  in  1  one-cycle read strobe
- `rdData`  out  DATA_WIDTH  read data, combinational from `rdAddr`
- `sample_strobe`  in  1  one-cycle pulse per audio sample
- `clip_i`  in  1  datapath saturation pulse
- `gain_o`  out  NUM_BANDS*GAIN_WIDTH  active gains; band 0 in the LSBs
- `eq_enable_o`  out  1  CTRL[0]
- `eq_bypass_o`  out  1  CTRL[1]

## Operation
- **Address map** (word-aligned; `addr[1:0]` ignored):
  - 0x00 CTRL: RW, bits[1:0]
  - 0x04 STATUS: RO. Bit0 = commit_pending. Bit1 = clip_sticky.
  - 0x08 COMMIT: WO; any write requests a commit
  - 0x0C SAMPLE_CNT: RO, 32-bit
  - 0x10 + 4·n GAIN[n]: RW, accesses the shadow register for n < NUM_BANDS
  - 0x30 ID: RO, constant 32'hE0A1_0001
- **Write behaviour:**
  - Writes take `wrData[GAIN_WIDTH-1:0]`. There are no byte strobes.
  - Writes to RO or unmapped addresses are ignored.
- **Read behaviour:**
  - Unmapped addresses read 0.
  - Unused upper bits read 0.
  - Reading GAIN[n] returns the shadow value, not the active value.
- **Commit state machine**, two states:
  - IDLE → PENDING on a COMMIT write.
  - PENDING → IDLE on `sample_strobe`. In that cycle active ← shadow (all bands at once).
  - A COMMIT write while PENDING is absorbed and the state stays PENDING.
- **SAMPLE_CNT:** increments on `sample_strobe` while CTRL[0] = 1; wraps 0xFFFF_FFFF → 0.
- **clip_sticky:** set by `clip_i`; cleared by a `rd` of STATUS.

## Timing
- **Reset values:**
  - `rdData` follows `rdAddr` (ID readable during reset).
  - `gain_o` = all bands GAIN_RESET.
  - `eq_enable_o` = 0, `eq_bypass_o` = 0.
  - State IDLE; SAMPLE_CNT = 0; clip_sticky = 0.
- **Latency:**
  - Register writes are visible on `rdData` and CTRL outputs the cycle after `wr`.
  - `rdData` is zero-latency: valid in the same cycle as `rdAddr`.
  - `gain_o` updates the cycle after the committing `sample_strobe`.
- **Simultaneous events:**
  - COMMIT write and `sample_strobe` in the same cycle while IDLE: the strobe does not commit. The state goes to PENDING and the commit applies at the next strobe.
  - GAIN write and committing strobe in the same cycle: active takes the pre-write shadow value; the shadow takes the new value.
  - `clip_i` and STATUS read in the same cycle: the read returns the pre-cycle value and clip_sticky ends set (set wins).
- **Reset mid-operation:** a pending commit is discarded and active gains return to GAIN_RESET asynchronously.

## Configuration
- **`EQ_REG_BANK_CLIPCNT_EN` defined:**
  - Adds a 16-bit clip counter at 0x34.
  - Increments on `clip_i` and saturates at 0xFFFF.
  - Cleared by a `rd` of 0x34. If `clip_i` arrives in the same cycle, the counter becomes 1.
- **`EQ_REG_BANK_CLIPCNT_EN` undefined:** no counter logic exists and 0x34 reads 0.

## Structure
- **Shared package `eq_reg_pkg`:**
  - Register offset constants.
  - ID value.
  - STATUS/CTRL bit indices.
  - GAIN_RESET default.
  - Commit-state encoding.
- **Sub-module `eq_gain_dbuf`:** one shadow/active pair per band, instantiated NUM_BANDS times. Inputs are write-enable, data and commit; output is active.
- The top level holds decode, CTRL, STATUS, counters and the commit FSM.

## Test plan
1. **Reset defaults:** after reset:
   - `gain_o` = 8×0x4000.
   - Reading 0x30 returns 0xE0A10001.
   - Reading 0x3C returns 0.
2. **Commit flow:**
   - Write GAIN[3] = 0x2000; `gain_o` band 3 stays 0x4000.
   - Write COMMIT; STATUS reads 1.
   - Pulse `sample_strobe`; band 3 = 0x2000 the next cycle and STATUS reads 0.
3. **Coincident commit and strobe:** COMMIT write with `sample_strobe` in the same cycle → no update. The next strobe applies it.
4. **Sticky clip:**
   - Pulse `clip_i` → STATUS = 2.
   - Read STATUS with `clip_i` high → returns 2 and the bit stays set.
   - Plain read → next read returns 0.
5. **Sample counter:** CTRL = 1; preload via 0xFFFFFFFF strobes (or a force) → wraps to 0. With CTRL = 0, strobes leave the count unchanged.
6. **Clip counter** (`EQ_REG_BANK_CLIPCNT_EN` only): 70000 `clip_i` pulses → 0x34 reads 0xFFFF, then reads 0 after that read.

Source files
------------

// File: rtl/eq_reg_pkg.sv
// Shared constants for the equalizer register bank: the address map, the ID value,
// the CTRL and STATUS bit positions, the default gain and the commit-state encoding.
package eq_reg_pkg;

    localparam logic [31:0] REG_CTRL       = 32'h00;
    localparam logic [31:0] REG_STATUS     = 32'h04;
    localparam logic [31:0] REG_COMMIT     = 32'h08;
    localparam logic [31:0] REG_SAMPLE_CNT = 32'h0C;
    localparam logic [31:0] REG_GAIN0      = 32'h10;
    localparam logic [31:0] REG_ID         = 32'h30;
    localparam logic [31:0] REG_CLIPCNT    = 32'h34;

    localparam logic [31:0] EQ_ID = 32'hE0A1_0001;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_BYPASS_BIT    = 1;
    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_CLIP_BIT    = 1;

    // Unity gain in signed Q2.14
    localparam logic [15:0] GAIN_RESET_DEFAULT = 16'h4000;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_state_t;

endpackage

// File: rtl/eq_reg_bank_dbuf.sv
// One band's gain: the shadow copy that software writes and the active copy that
// the filter datapath uses. The active copy loads the shadow only on commit.
module eq_gain_dbuf
    import eq_reg_pkg::*;
#(
    parameter int                    GAIN_WIDTH = 16,
    parameter logic [GAIN_WIDTH-1:0] GAIN_RESET = GAIN_RESET_DEFAULT
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [GAIN_WIDTH-1:0] i_data,
    input  logic                  i_commit,
    output logic [GAIN_WIDTH-1:0] o_shadow,
    output logic [GAIN_WIDTH-1:0] o_active
);

    logic [GAIN_WIDTH-1:0] r_shadow;
    logic [GAIN_WIDTH-1:0] r_active;

    // A write and a commit in the same cycle leave active with the pre-write shadow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= GAIN_RESET;
            r_active <= GAIN_RESET;
        end else begin
            if (i_we) begin
                r_shadow <= i_data;
            end
            if (i_commit) begin
                r_active <= r_shadow;
            end
        end
    end

    assign o_shadow = r_shadow;
    assign o_active = r_active;

endmodule

// File: rtl/eq_reg_bank.sv
// Equalizer register bank with double-buffered band gains committed on a sample strobe.
// Optional EQ_REG_BANK_CLIPCNT_EN adds a saturating 16-bit clip counter at 0x34.
module eq_reg_bank
    import eq_reg_pkg::*;
#(
    parameter int                    C_S_AXI_ADDR_WIDTH = 6,
    parameter int                    C_S_AXI_DATA_WIDTH = 32,
    parameter int                    NUM_BANDS          = 8,
    parameter int                    GAIN_WIDTH         = 16,
    parameter logic [GAIN_WIDTH-1:0] GAIN_RESET         = GAIN_RESET_DEFAULT
)(
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     wrAddr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     wrData,
    input  logic                              wr,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     rdAddr,
    input  logic                              rd,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     rdData,
    input  logic                              sample_strobe,
    input  logic                              clip_i,
    output logic [NUM_BANDS*GAIN_WIDTH-1:0]   gain_o,
    output logic                              eq_enable_o,
    output logic                              eq_bypass_o
);

    logic [31:0]           w_wr_addr;
    logic [31:0]           w_rd_addr;
    logic                  w_wr_ctrl;
    logic                  w_wr_commit;
    logic                  w_rd_status;
    logic [NUM_BANDS-1:0]  w_gain_we;
    logic [GAIN_WIDTH-1:0] w_shadow [NUM_BANDS];
    logic                  w_commit;
    logic                  w_pending;
    logic [31:0]           w_rd_data;
    logic                  w_unused;

    commit_state_t r_state;
    commit_state_t w_state_next;
    logic [1:0]    r_ctrl;
    logic [31:0]   r_sample_cnt;
    logic          r_clip_sticky;

    // Word-aligned decode: the byte-lane bits are dropped before comparing
    assign w_wr_addr   = 32'({wrAddr[C_S_AXI_ADDR_WIDTH-1:2], 2'b00});
    assign w_rd_addr   = 32'({rdAddr[C_S_AXI_ADDR_WIDTH-1:2], 2'b00});
    assign w_wr_ctrl   = wr && (w_wr_addr == REG_CTRL);
    assign w_wr_commit = wr && (w_wr_addr == REG_COMMIT);
    assign w_rd_status = rd && (w_rd_addr == REG_STATUS);
    assign w_unused    = ^{wrData[C_S_AXI_DATA_WIDTH-1:GAIN_WIDTH], wrAddr[1:0], rdAddr[1:0]};

    generate
        for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_band
            assign w_gain_we[gi] = wr && (w_wr_addr == REG_GAIN0 + 32'(4 * gi));

            eq_gain_dbuf #(
                .GAIN_WIDTH (GAIN_WIDTH),
                .GAIN_RESET (GAIN_RESET)
            ) u_dbuf (
                .clk      (S_AXI_ACLK),
                .rst      (S_AXI_ARESET),
                .i_we     (w_gain_we[gi]),
                .i_data   (wrData[GAIN_WIDTH-1:0]),
                .i_commit (w_commit),
                .o_shadow (w_shadow[gi]),
                .o_active (gain_o[gi*GAIN_WIDTH +: GAIN_WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Only a strobe seen while already pending commits, so a COMMIT write
    // coinciding with a strobe waits for the following one
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_commit) begin
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (sample_strobe) begin
                    w_commit     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_pending = (r_state == ST_PENDING);

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_ctrl        <= 2'b00;
            r_sample_cnt  <= 32'd0;
            r_clip_sticky <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= wrData[1:0];
            end
            if (sample_strobe && r_ctrl[CTRL_ENABLE_BIT]) begin
                r_sample_cnt <= r_sample_cnt + 32'd1;
            end
            if (clip_i) begin
                r_clip_sticky <= 1'b1;
            end else if (w_rd_status) begin
                r_clip_sticky <= 1'b0;
            end
        end
    end

`ifdef EQ_REG_BANK_CLIPCNT_EN
    logic [15:0] r_clip_cnt;
    logic        w_rd_clipcnt;

    assign w_rd_clipcnt = rd && (w_rd_addr == REG_CLIPCNT);

    // A clip arriving with the clearing read is counted rather than lost
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_clip_cnt <= 16'd0;
        end else if (w_rd_clipcnt) begin
            r_clip_cnt <= clip_i ? 16'd1 : 16'd0;
        end else if (clip_i && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        w_rd_data = 32'd0;
        case (w_rd_addr)
            REG_CTRL: w_rd_data = 32'(r_ctrl);
            REG_STATUS: begin
                w_rd_data[STATUS_PENDING_BIT] = w_pending;
                w_rd_data[STATUS_CLIP_BIT]    = r_clip_sticky;
            end
            REG_SAMPLE_CNT: w_rd_data = r_sample_cnt;
            REG_ID:         w_rd_data = EQ_ID;
`ifdef EQ_REG_BANK_CLIPCNT_EN
            REG_CLIPCNT:    w_rd_data = 32'(r_clip_cnt);
`endif
            default: w_rd_data = 32'd0;
        endcase
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (w_rd_addr == REG_GAIN0 + 32'(4 * b)) begin
                w_rd_data = 32'(w_shadow[b]);
            end
        end
    end

    assign rdData      = w_rd_data[C_S_AXI_DATA_WIDTH-1:0];
    assign eq_enable_o = r_ctrl[CTRL_ENABLE_BIT];
    assign eq_bypass_o = r_ctrl[CTRL_BYPASS_BIT];

endmodule

// File: tb/tb_eq_reg_bank.sv
// Directed bench for eq_reg_bank; expected values are queued when stimulus is driven
// and popped when the corresponding output is sampled.
module tb_eq_reg_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   wrAddr;
    logic [31:0]  wrData;
    logic         wr;
    logic [5:0]   rdAddr;
    logic         rd;
    logic [31:0]  rdData;
    logic         sample_strobe;
    logic         clip_i;
    logic [127:0] gain_o;
    logic         eq_enable_o;
    logic         eq_bypass_o;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    eq_reg_bank dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .wrAddr        (wrAddr),
        .wrData        (wrData),
        .wr            (wr),
        .rdAddr        (rdAddr),
        .rd            (rd),
        .rdData        (rdData),
        .sample_strobe (sample_strobe),
        .clip_i        (clip_i),
        .gain_o        (gain_o),
        .eq_enable_o   (eq_enable_o),
        .eq_bypass_o   (eq_bypass_o)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] val, input string tag);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
            $display("check %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [5:0] addr, input logic [31:0] data, input logic strb);
        wrAddr        = addr;
        wrData        = data;
        wr            = 1'b1;
        sample_strobe = strb;
        tick();
        wr            = 1'b0;
        sample_strobe = 1'b0;
    endtask

    task automatic strobe();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    task automatic rd_check(input logic [5:0] addr, input logic do_rd, input logic [31:0] exp,
                            input string tag);
        push(exp, tag);
        rdAddr = addr;
        rd     = do_rd;
        @(negedge clk);
        compare(rdData);
        tick();
        rd = 1'b0;
    endtask

    task automatic gain_check(input int band, input logic [15:0] exp, input string tag);
        push(32'(exp), tag);
        @(negedge clk);
        compare(32'(gain_o[band*16 +: 16]));
    endtask

    initial begin
        rst = 1'b1;
        wrAddr = '0; wrData = '0; wr = 1'b0;
        rdAddr = 6'h30; rd = 1'b0;
        sample_strobe = 1'b0; clip_i = 1'b0;

        // Reset defaults, sampled while reset is still asserted
        #1;
        push(32'hE0A1_0001, "id_in_reset");   compare(rdData);
        push(32'd0, "ctrl_out_in_reset");     compare({30'd0, eq_bypass_o, eq_enable_o});
        push(32'h4000_4000, "gain_b1b0_reset"); compare(gain_o[31:0]);
        push(32'h4000_4000, "gain_b7b6_reset"); compare(gain_o[127:96]);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        rd_check(6'h30, 1'b1, 32'hE0A1_0001, "id");
        rd_check(6'h3C, 1'b1, 32'd0,         "unmapped_3c");
        rd_check(6'h04, 1'b1, 32'd0,         "status_reset");
        rd_check(6'h0C, 1'b1, 32'd0,         "sample_cnt_reset");
        rd_check(6'h10, 1'b1, 32'h4000,      "gain0_shadow_reset");

        // Commit flow; upper write-data bits must be dropped
        wr_reg(6'h1C, 32'hABCD_2000, 1'b0);
        rd_check(6'h1C, 1'b1, 32'h2000, "gain3_shadow");
        gain_check(3, 16'h4000, "gain3_before_commit");
        wr_reg(6'h08, 32'd0, 1'b0);
        rd_check(6'h04, 1'b0, 32'd1, "status_pending");
        sample_strobe = 1'b1;
        gain_check(3, 16'h4000, "gain3_during_strobe");
        tick();
        sample_strobe = 1'b0;
        gain_check(3, 16'h2000, "gain3_after_commit");
        rd_check(6'h04, 1'b0, 32'd0, "status_idle");

        // Coincident COMMIT write and strobe: applied only at the next strobe
        wr_reg(6'h24, 32'h1234, 1'b0);
        wr_reg(6'h08, 32'd1, 1'b1);
        gain_check(5, 16'h4000, "gain5_coincident_no_commit");
        rd_check(6'h04, 1'b0, 32'd1, "status_pending_coincident");
        strobe();
        gain_check(5, 16'h1234, "gain5_next_strobe");

        // GAIN write together with the committing strobe
        wr_reg(6'h10, 32'h1111, 1'b0);
        wr_reg(6'h08, 32'd0, 1'b0);
        wr_reg(6'h10, 32'h2222, 1'b1);
        gain_check(0, 16'h1111, "gain0_pre_write_value");
        rd_check(6'h10, 1'b0, 32'h2222, "gain0_shadow_new");
        wr_reg(6'h08, 32'd0, 1'b0);
        strobe();
        gain_check(0, 16'h2222, "gain0_second_commit");

        // Sticky clip
        clip_i = 1'b1; tick(); clip_i = 1'b0;
        rd_check(6'h04, 1'b0, 32'd2, "status_clip_set");
        clip_i = 1'b1;
        rd_check(6'h04, 1'b1, 32'd2, "status_read_with_clip");
        clip_i = 1'b0;
        rd_check(6'h04, 1'b1, 32'd2, "status_clip_survived");
        rd_check(6'h04, 1'b1, 32'd0, "status_clip_cleared");

        // CTRL and sample counter
        wr_reg(6'h00, 32'd3, 1'b0);
        rd_check(6'h00, 1'b1, 32'd3, "ctrl_readback");
        push(32'd3, "ctrl_outputs"); compare({30'd0, eq_bypass_o, eq_enable_o});
        wr_reg(6'h00, 32'hFFFF_FFFD, 1'b0);
        rd_check(6'h00, 1'b1, 32'd1, "ctrl_masked");
        repeat (3) strobe();
        rd_check(6'h0C, 1'b1, 32'd3, "sample_cnt_3");
        @(negedge clk);
        force dut.r_sample_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_sample_cnt;
        rd_check(6'h0C, 1'b1, 32'hFFFF_FFFF, "sample_cnt_preload");
        strobe();
        rd_check(6'h0C, 1'b1, 32'd0, "sample_cnt_wrap");
        strobe();
        wr_reg(6'h00, 32'd0, 1'b0);
        repeat (2) strobe();
        rd_check(6'h0C, 1'b1, 32'd1, "sample_cnt_disabled_hold");

        // Writes to read-only and unmapped addresses are ignored
        wr_reg(6'h30, 32'd0, 1'b0);
        rd_check(6'h30, 1'b1, 32'hE0A1_0001, "id_after_write");
        wr_reg(6'h0C, 32'd55, 1'b0);
        rd_check(6'h0C, 1'b1, 32'd1, "sample_cnt_after_write");
        wr_reg(6'h3C, 32'hFFFF, 1'b0);
        rd_check(6'h3C, 1'b1, 32'd0, "unmapped_after_write");
        rd_check(6'h31, 1'b1, 32'hE0A1_0001, "id_low_bits_ignored");

        // Reset mid-operation discards the pending commit
        wr_reg(6'h14, 32'h0AAA, 1'b0);
        wr_reg(6'h08, 32'd0, 1'b0);
        rd_check(6'h04, 1'b0, 32'd1, "status_pending_before_reset");
        rdAddr = 6'h04;
        #2 rst = 1'b1;
        #1;
        push(32'h4000, "gain3_async_reset"); compare(32'(gain_o[63:48]));
        push(32'd0, "status_async_reset");   compare(rdData);
        tick();
        rst = 1'b0;
        strobe();
        gain_check(1, 16'h4000, "gain1_pending_discarded");

`ifdef EQ_REG_BANK_CLIPCNT_EN
        clip_i = 1'b1;
        repeat (70000) tick();
        clip_i = 1'b0;
        rd_check(6'h34, 1'b1, 32'hFFFF, "clipcnt_saturated");
        rd_check(6'h34, 1'b0, 32'd0,    "clipcnt_cleared");
        clip_i = 1'b1; tick(); clip_i = 1'b0;
        clip_i = 1'b1;
        rd_check(6'h34, 1'b1, 32'd1, "clipcnt_read_with_clip");
        clip_i = 1'b0;
        rd_check(6'h34, 1'b0, 32'd1, "clipcnt_restart_at_one");
`else
        clip_i = 1'b1; tick(); clip_i = 1'b0;
        rd_check(6'h34, 1'b1, 32'd0, "clipcnt_absent");
`endif

        if (sb.size() != 0) begin
            n_checks++;
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
